dsp_wdata_channel: RTL and testbench
====================================

Name: dsp_wdata_channel

Overview:
Master-side write-data dispatcher: one instance per master port of the interconnect. Takes the master's W beats and routes each burst to the slave-arbiter WDATA stage chosen by the matching AW transaction. Routing order comes from an order FIFO of {slave ID, AxLEN} written at AW acceptance. Sits directly upstream of every slave arbiter's WDATA channel and drives that arbiter's per-master dsp_WDATA/WLAST/WVALID slice.

Parameters:
SLV_AMT, 2, number of slave arbiters this dispatcher can route to
SLV_ID_W, $clog2(SLV_AMT), width of the slave index
OUTSTANDING_AMT, 8, order FIFO depth (power of 2), i.e. max AW bursts accepted ahead of W data
DATA_WIDTH, 32, W data width
TRANS_DATA_LEN_W, 3, width of AxLEN; burst length = AxLEN+1 beats

Ports:
ACLK_i  in  1  clock
ARESETn_i  in  1  reset, asynchronous, active-low
m_WDATA_i  in  DATA_WIDTH  master write data
m_WLAST_i  in  1  master last-beat flag (checked only with the optional feature)
m_WVALID_i  in  1  master beat valid
m_WREADY_o  out  1  beat accepted from master
AW_slv_id_i  in  SLV_ID_W  target slave of the accepted AW
AW_AxLEN_i  in  TRANS_DATA_LEN_W  AxLEN of the accepted AW
AW_fifo_order_wr_en_i  in  1  push {AW_slv_id_i, AW_AxLEN_i} into the order FIFO
AW_stall_o  out  1  order FIFO full; AW channel must not push
sa_WDATA_o  out  DATA_WIDTH*SLV_AMT  data to each slave arbiter; slice s = bits [DATA_WIDTH*(s+1)-1 -: DATA_WIDTH]; all slices carry the same registered data
sa_WLAST_o  out  SLV_AMT  last flag, one-hot to the selected slave
sa_WVALID_o  out  SLV_AMT  valid, one-hot to the selected slave, else 0
sa_WREADY_i  in  SLV_AMT  ready from each slave arbiter

Behaviour:
- Reset (async assert, release synchronous to ACLK_i): FIFO empty, state IDLE, beat counter 0, output register invalid. m_WREADY_o=0, sa_WVALID_o=0, sa_WLAST_o=0, sa_WDATA_o=0, AW_stall_o=0. Reset mid-burst discards all in-flight beats and FIFO entries.
- Order FIFO: first-word-fall-through. A push is visible as head on the cycle after the push. AW_stall_o = full. A push while full is ignored (protocol violation; FIFO contents unchanged). Pop and push in the same cycle are both legal when full.
- States: IDLE (FIFO empty) and BURST (head valid, beats being accepted).
  - IDLE->BURST when the FIFO is non-empty.
  - BURST->IDLE on the last-beat handshake if the FIFO becomes empty; otherwise stay in BURST with the new head, with no bubble.
- Master handshake: m_WREADY_o = BURST & (~out_valid | sa_WREADY_i[out_sel]). A beat is accepted when m_WVALID_i & m_WREADY_o.
- On acceptance:
  - The output register loads data, out_sel = head slave ID, and out_last = (cnt == head AxLEN).
  - cnt increments, modulo 2^TRANS_DATA_LEN_W. When out_last is set, cnt clears to 0 and the FIFO pops.
- Output register: sa_WVALID_o[s] = out_valid & (out_sel == s); sa_WLAST_o likewise gated. It clears when the selected slave handshakes and no new beat is loaded in the same cycle. Latency: master handshake to sa_WVALID_o is 1 cycle. Full throughput, 1 beat/cycle, while the selected slave keeps its ready high.
- Bursts to different slaves are serialized in AW order. A beat for burst N+1 may load in the same cycle the last beat of burst N hands off.
- sa_WREADY_i of non-selected slaves is ignored. Output is held stable while valid and not ready (AXI rule).
- AxLEN = 0: every beat is last, with one pop per beat. AxLEN = max (7): the counter reaches 7 and then clears, with no overflow.

Optional Feature:
WLAST_CHECK_EN.
- Defined: adds output wlast_err_o (1 bit, reset 0). It is a sticky flag, set on any accepted beat where m_WLAST_i != (cnt == head AxLEN), and cleared only by reset. Routing still follows the counter.
- Undefined: m_WLAST_i is unused, the port wlast_err_o does not exist, and no extra logic is generated.

Test Plan:
1. Reset → push {slv=1, len=3}, then drive 4 beats 0xA0..0xA3 back-to-back with sa_WREADY_i=2'b11 → sa_WVALID_o=2'b10 for 4 consecutive cycles starting 1 cycle after the first acceptance; sa_WLAST_o=2'b10 only on 0xA3; FIFO empty afterwards; state IDLE.
2. Push {0,0}, {1,1}, {0,0}, then stream 4 beats → sa_WVALID_o sequence 01, 10, 10, 01 with WLAST on beats 1, 3 and 4; no idle cycle between bursts.
3. Backpressure: burst {0,1}, hold sa_WREADY_i[0]=0 for 3 cycles → sa_WDATA_o slice 0 stable; m_WREADY_o=0 after the first beat; resumes on ready with no beat lost or duplicated.
4. Push 8 entries with no W data → AW_stall_o=1; a 9th push is ignored; one full burst drains → AW_stall_o=0 the cycle after the pop.
5. Assert ARESETn_i=0 mid-burst (beat 2 of 4), asynchronously → all outputs 0 immediately; after release, a new {1,0} burst routes correctly with cnt starting at 0.
6. With WLAST_CHECK_EN: burst len=2 with m_WLAST_i asserted on beat 1 → wlast_err_o=1 from the next cycle and remains set; sa_WLAST_o still fires on beat 3.

Source files
------------

// File: rtl/dsp_wdata_channel.sv
// rtl/dsp_wdata_channel.sv - master-side W beat dispatcher routing bursts to slave arbiters in AW order (optional WLAST_CHECK_EN)
module dsp_wdata_channel #(
    parameter int SLV_AMT          = 2,
    parameter int SLV_ID_W         = $clog2(SLV_AMT),
    parameter int OUTSTANDING_AMT  = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
) (
    input  logic                           ACLK_i,
    input  logic                           ARESETn_i,
    input  logic [DATA_WIDTH-1:0]          m_WDATA_i,
    input  logic                           m_WLAST_i,
    input  logic                           m_WVALID_i,
    output logic                           m_WREADY_o,
    input  logic [SLV_ID_W-1:0]            AW_slv_id_i,
    input  logic [TRANS_DATA_LEN_W-1:0]    AW_AxLEN_i,
    input  logic                           AW_fifo_order_wr_en_i,
    output logic                           AW_stall_o,
    output logic [DATA_WIDTH*SLV_AMT-1:0]  sa_WDATA_o,
    output logic [SLV_AMT-1:0]             sa_WLAST_o,
    output logic [SLV_AMT-1:0]             sa_WVALID_o,
    input  logic [SLV_AMT-1:0]             sa_WREADY_i
`ifdef WLAST_CHECK_EN
    ,
    output logic                           wlast_err_o
`endif
);

    localparam int PTR_W = $clog2(OUTSTANDING_AMT);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SLV_ID_W-1:0]         slv;
        logic [TRANS_DATA_LEN_W-1:0] len;
    } order_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    // Order FIFO storage and bookkeeping
    order_t                      fifo_mem [OUTSTANDING_AMT];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            fifo_cnt;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        fifo_push;
    logic                        fifo_pop;
    order_t                      head;

    // Burst tracking and output register
    state_t                      state;
    state_t                      state_nxt;
    logic [TRANS_DATA_LEN_W-1:0] beat_cnt;
    logic                        beat_acc;
    logic                        beat_last;
    logic                        out_valid;
    logic                        out_last;
    logic [SLV_ID_W-1:0]         out_sel;
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        out_hs;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(OUTSTANDING_AMT));
    assign head       = fifo_mem[rd_ptr];
    assign AW_stall_o = fifo_full;

    // A beat matching the head AxLEN closes the burst and retires its FIFO entry.
    assign beat_last  = (beat_cnt == head.len);
    assign beat_acc   = m_WVALID_i & m_WREADY_o;
    assign fifo_pop   = beat_acc & beat_last;
    // When full, a push is only taken if a slot frees up in the same cycle.
    assign fifo_push  = AW_fifo_order_wr_en_i & (~fifo_full | fifo_pop);
    assign out_hs     = out_valid & sa_WREADY_i[out_sel];

    // Order FIFO payload write (no reset needed: entries are qualified by fifo_cnt)
    always_ff @(posedge ACLK_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= '{slv: AW_slv_id_i, len: AW_AxLEN_i};
        end
    end

    // Order FIFO pointers and occupancy
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Dispatcher state register
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and master ready: back to IDLE only when the last beat drains the FIFO
    always_comb begin
        state_nxt  = state;
        m_WREADY_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                m_WREADY_o = ~out_valid | sa_WREADY_i[out_sel];
                if (fifo_pop && (fifo_cnt == CNT_W'(1)) && !fifo_push) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Beat counter within the current burst; wraps to 0 on the last beat
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            beat_cnt <= '0;
        end else if (beat_acc) begin
            if (beat_last) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Output register: load on master acceptance, drop after the selected slave takes it
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            out_data  <= '0;
        end else if (beat_acc) begin
            out_valid <= 1'b1;
            out_last  <= beat_last;
            out_sel   <= head.slv;
            out_data  <= m_WDATA_i;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    // Fan the registered beat out; only the selected slave sees valid/last
    always_comb begin
        sa_WDATA_o  = '0;
        sa_WVALID_o = '0;
        sa_WLAST_o  = '0;
        for (int s = 0; s < SLV_AMT; s++) begin
            sa_WDATA_o[s*DATA_WIDTH +: DATA_WIDTH] = out_data;
            sa_WVALID_o[s] = out_valid & (out_sel == SLV_ID_W'(s));
            sa_WLAST_o[s]  = out_valid & out_last & (out_sel == SLV_ID_W'(s));
        end
    end

`ifdef WLAST_CHECK_EN
    // Sticky flag for master WLAST disagreeing with the AW-derived burst length
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wlast_err_o <= 1'b0;
        end else if (beat_acc && (m_WLAST_i != beat_last)) begin
            wlast_err_o <= 1'b1;
        end
    end
`else
    // Master WLAST is not consulted in this build; routing follows the counter only
    wire unused_wlast = m_WLAST_i;
`endif

endmodule

// File: tb/tb_dsp_wdata_channel.sv
// tb/tb_dsp_wdata_channel.sv - scoreboard bench for dsp_wdata_channel with random stimulus
module tb_dsp_wdata_channel;

    localparam int SLV_AMT = 2;
    localparam int DW      = 32;
    localparam int LW      = 3;
    localparam int DEPTH   = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [DW-1:0]          wdata = '0;
    logic                   wlast = 1'b0;
    logic                   wvalid = 1'b0;
    logic                   m_wready;
    logic [0:0]             aw_slv = '0;
    logic [LW-1:0]          aw_len = '0;
    logic                   aw_wr = 1'b0;
    logic                   aw_stall;
    logic [DW*SLV_AMT-1:0]  sa_wdata;
    logic [SLV_AMT-1:0]     sa_wlast;
    logic [SLV_AMT-1:0]     sa_wvalid;
    logic [SLV_AMT-1:0]     sa_wready = 2'b11;
`ifdef WLAST_CHECK_EN
    logic                   wlast_err;
`endif

    dsp_wdata_channel #(
        .SLV_AMT(SLV_AMT), .SLV_ID_W(1), .OUTSTANDING_AMT(DEPTH),
        .DATA_WIDTH(DW), .TRANS_DATA_LEN_W(LW)
    ) dut (
        .ACLK_i(clk), .ARESETn_i(rst_n),
        .m_WDATA_i(wdata), .m_WLAST_i(wlast), .m_WVALID_i(wvalid), .m_WREADY_o(m_wready),
        .AW_slv_id_i(aw_slv), .AW_AxLEN_i(aw_len), .AW_fifo_order_wr_en_i(aw_wr),
        .AW_stall_o(aw_stall),
        .sa_WDATA_o(sa_wdata), .sa_WLAST_o(sa_wlast), .sa_WVALID_o(sa_wvalid),
        .sa_WREADY_i(sa_wready)
`ifdef WLAST_CHECK_EN
        , .wlast_err_o(wlast_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int slv; int len; } burst_t;
    typedef struct { int slv; logic [DW-1:0] data; bit last; } beat_t;

    burst_t mq[$];   // AW bursts the DUT holds, oldest first
    beat_t  eq[$];   // accepted beats awaiting delivery to a slave
    int     beat_idx = 0;
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;

    bit                     acc_prev = 0;
    beat_t                  acc_item;
    bit                     hold_prev = 0;
    logic [SLV_AMT-1:0]     hold_v;
    logic [SLV_AMT-1:0]     hold_l;
    logic [DW*SLV_AMT-1:0]  hold_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: inputs change just after posedge, so negedge values are what the next edge sees
    always @(negedge clk) begin : model
        int  sz;
        bit  pop_now;
        beat_t b;
        if (!rst_n) begin
            mq.delete();
            eq.delete();
            beat_idx  = 0;
            acc_prev  = 0;
            hold_prev = 0;
            check("rst_wready", {63'd0, m_wready}, 64'd0);
            check("rst_wvalid", {62'd0, sa_wvalid}, 64'd0);
            check("rst_wlast", {62'd0, sa_wlast}, 64'd0);
            check("rst_wdata", sa_wdata, 64'd0);
            check("rst_stall", {63'd0, aw_stall}, 64'd0);
        end else begin
            if (acc_prev) begin
                check("lat_valid", {62'd0, sa_wvalid}, 64'(2'b01 << acc_item.slv));
                check("lat_data", {32'd0, sa_wdata[acc_item.slv*DW +: DW]}, {32'd0, acc_item.data});
                check("lat_last", {62'd0, sa_wlast}, acc_item.last ? 64'(2'b01 << acc_item.slv) : 64'd0);
            end
            if (hold_prev) begin
                check("hold_valid", {62'd0, sa_wvalid}, {62'd0, hold_v});
                check("hold_data", sa_wdata, hold_d);
                check("hold_last", {62'd0, sa_wlast}, {62'd0, hold_l});
            end
            check("stall", {63'd0, aw_stall}, {63'd0, mq.size() == DEPTH});
            check("valid_onehot", {63'd0, $countones(sa_wvalid) > 1}, 64'd0);
            if (mq.size() == 0)
                check("idle_no_ready", {63'd0, m_wready}, 64'd0);
            if (|(sa_wvalid & ~sa_wready))
                check("bp_no_ready", {63'd0, m_wready}, 64'd0);

            sz       = mq.size();
            pop_now  = 0;
            acc_prev = 0;
            if (wvalid && m_wready) begin
                if (sz == 0) begin
                    check("accept_without_aw", {63'd0, m_wready}, 64'd0);
                end else begin
                    b.slv  = mq[0].slv;
                    b.data = wdata;
                    b.last = (beat_idx == mq[0].len);
                    eq.push_back(b);
                    acc_item = b;
                    acc_prev = 1;
                    if (b.last) begin
                        void'(mq.pop_front());
                        beat_idx = 0;
                        pop_now  = 1;
                    end else begin
                        beat_idx++;
                    end
                end
            end
            if (aw_wr && (sz < DEPTH || pop_now))
                mq.push_back('{int'(aw_slv), int'(aw_len)});
            hold_prev = |(sa_wvalid & ~sa_wready);
            hold_v    = sa_wvalid;
            hold_l    = sa_wlast;
            hold_d    = sa_wdata;
        end
    end

    // Monitor: each slave handshake delivers the oldest outstanding beat
    always @(negedge clk) begin : monitor
        beat_t b;
        if (rst_n) begin
            for (int s = 0; s < SLV_AMT; s++) begin
                if (sa_wvalid[s] && sa_wready[s]) begin
                    if (eq.size() == 0) begin
                        check("sb_unexpected_beat", {63'd0, sa_wvalid[s]}, 64'd0);
                    end else begin
                        b = eq.pop_front();
                        check("sb_slave", 64'(s), 64'(b.slv));
                        check("sb_data", {32'd0, sa_wdata[s*DW +: DW]}, {32'd0, b.data});
                        check("sb_last", {63'd0, sa_wlast[s]}, {63'd0, b.last});
                    end
                end
            end
        end
    end

    task automatic push_aw(input int s, input int l);
        aw_slv = 1'(s);
        aw_len = LW'(l);
        aw_wr  = 1'b1;
        @(posedge clk); #1;
        aw_wr  = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        wvalid = 1'b1;
        wdata  = d;
        while (acc_cyc < 0) begin
            @(negedge clk);
            if (m_wready) acc_cyc = cyc;
            @(posedge clk); #1;
            n++;
            if (acc_cyc < 0 && n > 200) begin
                check("beat_timeout", {63'd0, m_wready}, 64'd1);
                acc_cyc = 0;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || eq.size() != 0 || sa_wvalid != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 64'(n >= 500), 64'd0);
    endtask

    task automatic check_streak(input string name, input int c[], input int first);
        for (int i = first; i < c.size(); i++)
            check(name, 64'(c[i] - c[i-1]), 64'd1);
    endtask

    initial begin : stim
        int c[];
        int a;
        c = new[4];
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // single 4-beat burst to slave 1 at full rate
        push_aw(1, 3);
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + i, c[i]);
        wvalid = 1'b0;
        check_streak("t1_throughput", c, 1);
        wait_drain();

        // three back-to-back bursts across both slaves, no bubble at boundaries
        push_aw(0, 0);
        push_aw(1, 1);
        push_aw(0, 0);
        for (int i = 0; i < 4; i++) send_beat(32'hB0 + i, c[i]);
        wvalid = 1'b0;
        check_streak("t2_no_bubble", c, 1);
        wait_drain();

        // backpressure from slave 0 for three cycles
        sa_wready = 2'b10;
        push_aw(0, 1);
        send_beat(32'hC0, a);
        wdata = 32'hC1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_master_stalled", {63'd0, m_wready}, 64'd0);
            @(posedge clk); #1;
        end
        sa_wready = 2'b11;
        send_beat(32'hC1, a);
        wvalid = 1'b0;
        wait_drain();

        // fill the order FIFO, overfill once, then drain
        for (int i = 0; i < 9; i++) push_aw(i % 2, 1);
        @(negedge clk);
        check("t4_stall_full", {63'd0, aw_stall}, 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send_beat($urandom, a);
        wvalid = 1'b0;
        wait_drain();
        check("t4_overfill_ignored", 64'(mq.size()), 64'd0);

        // asynchronous reset in the middle of a burst
        push_aw(0, 3);
        send_beat(32'hD0, a);
        send_beat(32'hD1, a);
        wvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", {62'd0, sa_wvalid}, 64'd0);
        check("t5_async_wready", {63'd0, m_wready}, 64'd0);
        check("t5_async_data", sa_wdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push_aw(1, 0);
        send_beat(32'hE0, a);
        wvalid = 1'b0;
        wait_drain();

`ifdef WLAST_CHECK_EN
        push_aw(0, 2);
        wlast = 1'b1;
        send_beat(32'hF0, a);
        wlast = 1'b0;
        send_beat(32'hF1, a);
        send_beat(32'hF2, a);
        wvalid = 1'b0;
        @(negedge clk);
        check("t6_wlast_err", {63'd0, wlast_err}, 64'd1);
        wait_drain();
        check("t6_wlast_sticky", {63'd0, wlast_err}, 64'd1);
`endif

        // randomized traffic, including pushes while full and random slave readiness
        for (int i = 0; i < 2000; i++) begin
            aw_wr     = ($urandom_range(0, 2) == 0);
            aw_slv    = 1'($urandom_range(0, 1));
            aw_len    = LW'($urandom_range(0, 7));
            wvalid    = ($urandom_range(0, 9) < 7);
            wdata     = $urandom;
            wlast     = 1'($urandom_range(0, 1));
            sa_wready = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        aw_wr     = 1'b0;
        sa_wready = 2'b11;
        while (mq.size() != 0 && cyc < 60000) begin
            wvalid = 1'b1;
            wdata  = $urandom;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
